// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one imem read per cycle and
// buffers returned words in a 2-entry FIFO presented to decode over valid/ready.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_RUN  | normal fetch, requests issued while credit allows
// ST_HALT | no new requests; in-flight word lands, buffer drains
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              halt,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [31:0]       inst_pc,
  output logic              busy
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        inflight_q, inflight_d;
  logic        kill_q, kill_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] buf_pc_q [2];
  logic [31:0] buf_pc_d [2];
  logic [31:0] buf_data_q [2];
  logic [31:0] buf_data_d [2];

  logic        pop;
  logic        push;
  logic [2:0]  credit_used;
  logic [1:0]  wr_idx;
  logic        unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign inst_valid  = (count_q != 2'd0);
  assign pop         = inst_valid & inst_ready;
  assign push        = inflight_q & ~kill_q;
  // Slots already spoken for after this cycle's pop; pop implies count >= 1.
  assign credit_used = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign inst_data = inst_valid ? buf_data_q[0] : 32'h0;
  assign inst_pc   = inst_valid ? buf_pc_q[0]   : 32'h0;
  assign busy      = inflight_q | inst_valid;
  assign imem_addr = fetch_pc_q[ADDR_W+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (halt)  state_d = ST_HALT;
      ST_HALT: if (!halt) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    imem_req = ~rst & (state_q == ST_RUN) & ~halt & ~redirect_valid &
               (credit_used < 3'd2);
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = imem_req;
    kill_d        = redirect_valid & inflight_q;
    count_d       = count_q;
    buf_pc_d      = buf_pc_q;
    buf_data_d    = buf_data_q;
    wr_idx        = count_q - {1'b0, pop};

    if (imem_req) begin
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + 32'd4;
    end

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = 2'd0;
    end else begin
      if (pop) begin
        buf_pc_d[0]   = buf_pc_q[1];
        buf_data_d[0] = buf_data_q[1];
      end
      if (push) begin
        if (wr_idx == 2'd0) begin
          buf_pc_d[0]   = inflight_pc_q;
          buf_data_d[0] = imem_rdata;
        end else begin
          buf_pc_d[1]   = inflight_pc_q;
          buf_data_d[1] = imem_rdata;
        end
      end
      count_d = count_q - {1'b0, pop} + {1'b0, push};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC & ~32'd3;
      inflight_pc_q <= 32'h0;
      inflight_q    <= 1'b0;
      kill_q        <= 1'b0;
      count_q       <= 2'd0;
      buf_pc_q[0]   <= 32'h0;
      buf_pc_q[1]   <= 32'h0;
      buf_data_q[0] <= 32'h0;
      buf_data_q[1] <= 32'h0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      kill_q        <= kill_d;
      count_q       <= count_d;
      buf_pc_q      <= buf_pc_d;
      buf_data_q    <= buf_data_d;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && !redirect_valid && !pop && count_q == 2'd2));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: memory model, stream-level scoreboard of expected
// PCs, directed cycle checks and a randomized halt/redirect/backpressure run.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        busy;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halt(halt), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .busy(busy)
  );

  // Word i of memory holds 0x1000_0000 + i; unrequested cycles return noise.
  always @(posedge clk)
    imem_rdata <= imem_req ? (32'h1000_0000 + {24'h0, imem_addr}) : $urandom;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  logic [31:0] exp_q [$];
  logic [31:0] next_exp;
  logic [31:0] mon_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Decode must see a sequential stream, restarted at the target on redirect
  // and at the reset PC on reset.
  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_empty: got pc %h expected no instruction", inst_pc);
      end else begin
        mon_pc = exp_q.pop_front();
        chk("stream_pc", inst_pc, mon_pc);
        chk("stream_data", inst_data, 32'h1000_0000 + {24'h0, mon_pc[9:2]});
        accepted++;
      end
    end
  end

  task automatic model_update();
    if (rst) begin
      exp_q.delete();
      next_exp = 32'h0;
    end else if (redirect_valid) begin
      exp_q.delete();
      next_exp = {redirect_pc[31:2], 2'b00};
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_exp);
      next_exp = next_exp + 32'd4;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0; inst_ready = 1'b1;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    tick();
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0; inst_ready = 1'b1;
    next_exp = 32'h0;

    // Streaming
    do_reset();
    for (int c = 0; c < 24; c++) begin
      #1;
      if (c == 0) begin
        chk("c0_req", 32'(imem_req), 32'd1);
        chk("c0_addr", 32'(imem_addr), 32'h0);
      end
      if (c == 2) begin
        chk("c2_pc", inst_pc, 32'h0);
        chk("c2_data", inst_data, 32'h1000_0000);
      end
      if (c >= 2 && c <= 21) chk("stream_nogap", 32'(inst_valid), 32'd1);
      tick();
    end

    // Backpressure
    do_reset();
    for (int c = 0; c < 15; c++) begin
      inst_ready = !(c >= 2 && c <= 9);
      #1;
      if (c >= 2 && c <= 9) begin
        chk("bp_valid", 32'(inst_valid), 32'd1);
        chk("bp_req", 32'(imem_req), 32'd0);
        chk("bp_busy", 32'(busy), 32'd1);
      end
      if (c == 10) chk("bp_pc0", inst_pc, 32'h0);
      if (c == 11) chk("bp_pc1", inst_pc, 32'h4);
      if (c == 12) chk("bp_pc2", inst_pc, 32'h8);
      tick();
    end
    inst_ready = 1'b1;

    // Redirect
    do_reset();
    for (int c = 0; c < 12; c++) begin
      redirect_valid = (c == 6);
      redirect_pc = 32'h43;
      #1;
      if (c == 6) chk("rd_req_blocked", 32'(imem_req), 32'd0);
      if (c == 7) begin
        chk("rd_req", 32'(imem_req), 32'd1);
        chk("rd_addr", 32'(imem_addr), 32'h10);
      end
      if (c == 7 || c == 8) chk("rd_bubble", 32'(inst_valid), 32'd0);
      if (c == 9) begin
        chk("rd_valid", 32'(inst_valid), 32'd1);
        chk("rd_pc", inst_pc, 32'h40);
        chk("rd_data", inst_data, 32'h1000_0010);
      end
      tick();
    end
    redirect_valid = 1'b0;

    // Redirect with a simultaneous pop from a full buffer
    do_reset();
    for (int c = 0; c < 11; c++) begin
      inst_ready = !(c >= 2 && c <= 4);
      redirect_valid = (c == 5);
      redirect_pc = 32'h80;
      #1;
      if (c == 5) chk("rp_head", inst_pc, 32'h0);
      if (c == 6 || c == 7) chk("rp_bubble", 32'(inst_valid), 32'd0);
      if (c == 8) chk("rp_target", inst_pc, 32'h80);
      tick();
    end
    redirect_valid = 1'b0;
    inst_ready = 1'b1;

    // Halt mid-stream
    do_reset();
    for (int c = 0; c < 12; c++) begin
      halt = (c >= 6 && c <= 10);
      #1;
      if (halt) chk("halt_req", 32'(imem_req), 32'd0);
      if (c == 10) begin
        chk("halt_busy", 32'(busy), 32'd0);
        chk("halt_empty", 32'(inst_valid), 32'd0);
      end
      tick();
    end
    begin
      bit found;
      found = 1'b0;
      for (int c = 0; c < 4 && !found; c++) begin
        #1;
        if (imem_req) begin
          found = 1'b1;
          chk("halt_resume_addr", 32'(imem_addr), 32'h6);
        end
        tick();
      end
      if (!found) begin
        checks++;
        errors++;
        $display("FAIL halt_resume: got no request within 4 cycles, expected one at addr 06");
      end
    end
    for (int c = 0; c < 6; c++) tick();

    // Reset together with redirect mid-stream
    do_reset();
    for (int c = 0; c < 8; c++) tick();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    #1;
    chk("rr_req", 32'(imem_req), 32'd0);
    tick();
    rst = 1'b0; redirect_valid = 1'b0;
    #1;
    chk("rr_valid", 32'(inst_valid), 32'd0);
    chk("rr_busy", 32'(busy), 32'd0);
    chk("rr_req_after", 32'(imem_req), 32'd1);
    chk("rr_addr", 32'(imem_addr), 32'h0);
    for (int c = 0; c < 6; c++) tick();

    // Word-address wrap
    do_reset();
    for (int c = 0; c < 11; c++) begin
      redirect_valid = (c == 4);
      redirect_pc = 32'h3FC;
      #1;
      if (c == 5) chk("wr_addr_ff", 32'(imem_addr), 32'hFF);
      if (c == 6) begin
        chk("wr_req", 32'(imem_req), 32'd1);
        chk("wr_addr_00", 32'(imem_addr), 32'h00);
      end
      if (c == 7) chk("wr_pc_3fc", inst_pc, 32'h3FC);
      if (c == 8) begin
        chk("wr_pc_400", inst_pc, 32'h400);
        chk("wr_data", inst_data, 32'h1000_0000);
      end
      tick();
    end
    redirect_valid = 1'b0;

    // Randomized traffic
    do_reset();
    begin
      int acc0;
      acc0 = accepted;
      for (int c = 0; c < 1500; c++) begin
        inst_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 19) == 0) halt = ~halt;
        redirect_valid = ($urandom_range(0, 15) == 0);
        redirect_pc = $urandom & 32'h0000_07FF;
        #1;
        if (halt || redirect_valid) chk("rand_req_blocked", 32'(imem_req), 32'd0);
        tick();
      end
      chk("rand_progress", 32'(accepted - acc0 > 200), 32'd1);
    end
    halt = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that sequences the word-addressed instruction memory for the RV32I core. Owns the program counter. Issues one read per cycle to the memory, captures returned words into a 2-entry instruction buffer, and hands them to decode over a valid/ready handshake. Also handles branch/jump redirects with flush and a halt request from the core controller.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] are ignored.
- ADDR_W, 8: instruction memory word-address width (256 words).
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  read request this cycle.
- imem_addr  out  ADDR_W  word address, equal to pc[ADDR_W+1:2].
- imem_rdata  in  32  read data, valid exactly one cycle after the request cycle.
- redirect_valid  in  1  taken branch/jump; single-cycle pulse.
- redirect_pc  in  32  redirect target; bits [1:0] are forced to 0.
- halt  in  1  level; while high, no new requests are issued.
- inst_valid  out  1  buffer head is valid.
- inst_ready  in  1  decode accepts the head.
- inst_data  out  32  instruction word at the buffer head.
- inst_pc  out  32  byte PC of inst_data.
- busy  out  1  request in flight or buffer non-empty.

## Operation
- FSM states:
  - RUN: normal fetch.
  - HALTED: no issue.
  - Reset enters RUN.
  - RUN→HALTED when halt=1.
  - HALTED→RUN when halt=0.
  - Halt does not flush. The in-flight response still lands and the buffer still drains.
- Registers:
  - fetch_pc (32 bits).
  - inflight (1 bit) and inflight_pc (32 bits).
  - kill (1 bit).
  - 2-entry FIFO of {pc, data} with count 0..2.
- pop = inst_valid & inst_ready.
- Issue rule: imem_req = RUN & !halt & !redirect_valid & (count + inflight − pop) < 2.
- On issue:
  - inflight ← 1 and inflight_pc ← fetch_pc.
  - fetch_pc ← fetch_pc + 4. The add is 32-bit and wraps modulo 2^32.
  - imem_addr truncation wraps the memory index.
- Response cycle (inflight=1): {inflight_pc, imem_rdata} is pushed unless kill=1. If no new issue occurs, inflight clears.
- Push and pop in the same cycle leave count unchanged. Order is preserved.
- Credit rule guarantees no push when full. A push when full is an assertion failure.
- Redirect (redirect_valid=1, any state):
  - A pop in the same cycle completes normally; decode owns that instruction.
  - FIFO is cleared at the edge, so count ← 0.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - If a request is in flight, kill ← 1 so its response is discarded next cycle.
  - No request is issued in the redirect cycle.
- Redirect while HALTED updates fetch_pc and flushes. Fetch resumes from the new PC when halt drops.
- busy = inflight | (count ≠ 0).
- rst overrides everything, including redirect and halt in the same cycle.

## Timing
- Reset values:
  - imem_req=0 while rst=1.
  - inst_valid=0, busy=0, count=0, inflight=0, kill=0.
  - fetch_pc=RESET_PC & ~3.
  - inst_data and inst_pc read 0 when empty.
- First cycle with rst=0 (cycle 0): imem_req=1, imem_addr=RESET_PC>>2.
- Latency: request in cycle N, then inst_valid with that word in cycle N+2.
- Throughput: one instruction per cycle when inst_ready is held high.
- Redirect in cycle R:
  - First request at the target in R+1.
  - Target instruction valid in R+3.
  - Penalty is 2 bubbles.
- inst_valid, inst_data and inst_pc are registered (FIFO head). There is no combinational path from imem_rdata or redirect_valid to them.
- imem_req depends combinationally on halt, redirect_valid and inst_ready.
- Reset asserted mid-operation: the next cycle shows reset values, and the in-flight response is ignored.

## Test plan
- Streaming: memory word i = 0x1000_0000+i, ready=1 from reset.
  - Cycle 2 shows pc 0x0, data 0x10000000.
  - Then one instruction per cycle with pc +4.
  - No gaps over 20 instructions.
- Backpressure: hold inst_ready=0 for cycles 2–9.
  - inst_valid stays 1 and count saturates at 2.
  - imem_req=0 after 2 requests.
  - On release, order is 0x0, 0x4, 0x8 with no loss or duplication.
- Redirect: redirect_pc=0x43 in cycle 6 with ready=1.
  - Killed in-flight word never appears.
  - Cycle 7 imem_addr=0x10.
  - Cycle 9 inst_pc=0x40.
- Redirect with simultaneous pop:
  - Head is accepted in the redirect cycle.
  - Second buffered entry is flushed.
  - Next valid inst_pc equals the target.
- Halt: assert halt for 5 cycles mid-stream.
  - imem_req=0 while halted.
  - Buffer drains and busy falls to 0.
  - After release, fetch resumes at the next sequential PC.
- Reset mid-stream together with redirect_valid:
  - Next cycle shows inst_valid=0, busy=0.
  - fetch_pc=RESET_PC and the redirect is ignored.
- Wrap-around: redirect to 0x3FC with ADDR_W=8.
  - Following request imem_addr=0x00.
  - inst_pc=0x400.
